// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and widths for the run-control sequencer
package cpu_ctrl_pkg;

  localparam int unsigned DEF_PC_W = 10;
  localparam int unsigned CYCLE_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - combinational next-pc: sequential step, absolute jump or relative branch
module pc_next_calc
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = DEF_PC_W
) (
  input  logic [PC_W-1:0] pc,
  input  logic            branch_taken,
  input  logic            abs_jump,
  input  logic [PC_W-1:0] target,
  input  logic [7:0]      rel_off,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] off_ext;

  // Size-casting a signed value sign-extends; the PC_W-bit add wraps modulo 2**PC_W.
  assign off_ext = PC_W'($signed(rel_off));

  always_comb begin
    next_pc = pc + PC_W'(1);
    if (branch_taken) begin
      next_pc = abs_jump ? target : (pc + off_ext);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter owner and IDLE/RUN/DONE run-control FSM with watchdog
module pc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned PC_W       = DEF_PC_W,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned PROG_LEN   = 1024,
  parameter int unsigned MAX_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               halt_req,
  input  logic               branch_taken,
  input  logic               abs_jump,
  input  logic [PC_W-1:0]    target,
  input  logic [7:0]         rel_off,
  output logic [PC_W-1:0]    pc,
  output logic               instr_valid,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CYCLE_W-1:0] cycle_count
);

  localparam logic [PC_W-1:0]    START_PC = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0]    END_PC   = PC_W'(PROG_LEN - 1);
  localparam logic [CYCLE_W-1:0] WD_LAST  = CYCLE_W'(MAX_CYCLES - 1);
  localparam bit                 WD_EN    = (MAX_CYCLES != 0);

  seq_state_t      state;
  logic [PC_W-1:0] next_pc;
  logic            wd_fire;
  logic            at_end;

  pc_next_calc #(.PC_W(PC_W)) u_pc_next_calc (
    .pc           (pc),
    .branch_taken (branch_taken),
    .abs_jump     (abs_jump),
    .target       (target),
    .rel_off      (rel_off),
    .next_pc      (next_pc)
  );

  assign wd_fire     = WD_EN && (cycle_count == WD_LAST);
  assign at_end      = (pc == END_PC);
  assign busy        = (state == RUN);
  assign instr_valid = busy && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= START_PC;
      cycle_count <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            pc          <= START_PC;
            cycle_count <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + CYCLE_W'(1);
          // Watchdog beats stall, halt and branch alike; stall masks halt and branch.
          if (wd_fire) begin
            state   <= DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else if (!stall) begin
            if (halt_req) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (branch_taken || !at_end) begin
              pc <= next_pc;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed-vector bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        halt_req = 1'b0;
  logic        branch_taken = 1'b0;
  logic        abs_jump = 1'b0;
  logic [9:0]  target = '0;
  logic [7:0]  rel_off = '0;
  logic [9:0]  pc;
  logic        instr_valid;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] cycle_count;

  int n_checks = 0;
  int n_pass   = 0;

  pc_sequencer #(
    .PC_W       (10),
    .START_ADDR (0),
    .PROG_LEN   (8),
    .MAX_CYCLES (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .halt_req     (halt_req),
    .branch_taken (branch_taken),
    .abs_jump     (abs_jump),
    .target       (target),
    .rel_off      (rel_off),
    .pc           (pc),
    .instr_valid  (instr_valid),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // reset state
    tick();
    tick();
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_cnt", cycle_count, 32'd0);
    check("rst_flags", {28'd0, busy, done, timeout, instr_valid}, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_hold", 32'(busy), 32'd0);

    // 1: straight-line run to fall-off end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_iv", 32'(instr_valid), 32'd1);
    check("t1_pc0", 32'(pc), 32'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("t1_pc%0d", i), 32'(pc), 32'(i));
    end
    check("t1_busy_at7", 32'(busy), 32'd1);
    tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_pc_hold", 32'(pc), 32'd7);
    check("t1_cnt", cycle_count, 32'd8);
    check("t1_timeout", 32'(timeout), 32'd0);
    check("t1_busy_off", 32'(busy), 32'd0);

    // 2: relative back-branch, absolute jump, relative wrap
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("t2_pc5", 32'(pc), 32'd5);
    branch_taken = 1'b1;
    abs_jump = 1'b0;
    rel_off = 8'hFD;
    tick();
    check("t2_rel_neg", 32'(pc), 32'd2);
    abs_jump = 1'b1;
    target = 10'h3F0;
    tick();
    check("t2_abs", 32'(pc), 32'h3F0);
    abs_jump = 1'b0;
    rel_off = 8'h10;
    tick();
    check("t2_rel_wrap", 32'(pc), 32'd0);
    branch_taken = 1'b0;
    do_reset();

    // 3: stall freezes pc and masks branch, counter keeps running
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("t3_pc3", 32'(pc), 32'd3);
    stall = 1'b1;
    branch_taken = 1'b1;
    abs_jump = 1'b1;
    target = 10'h100;
    #1;
    check("t3_iv_low", 32'(instr_valid), 32'd0);
    repeat (4) tick();
    check("t3_pc_held", 32'(pc), 32'd3);
    check("t3_cnt", cycle_count, 32'd7);
    check("t3_busy", 32'(busy), 32'd1);
    stall = 1'b0;
    branch_taken = 1'b0;
    tick();
    check("t3_resume", 32'(pc), 32'd4);
    repeat (4) tick();
    check("t3_done", 32'(done), 32'd1);
    check("t3_cnt_end", cycle_count, 32'd12);

    // 4: halt, frozen DONE, restart from DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_restart_cnt", cycle_count, 32'd0);
    repeat (6) tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("t4_halt_done", 32'(done), 32'd1);
    check("t4_halt_pc", 32'(pc), 32'd6);
    check("t4_halt_cnt", cycle_count, 32'd7);
    tick();
    check("t4_frozen_pc", 32'(pc), 32'd6);
    check("t4_frozen_cnt", cycle_count, 32'd7);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_re_pc", 32'(pc), 32'd0);
    check("t4_re_cnt", cycle_count, 32'd0);
    check("t4_re_done", 32'(done), 32'd0);

    // 5: branch-to-self loop hits watchdog, coincident halt loses
    branch_taken = 1'b1;
    abs_jump = 1'b1;
    target = 10'd0;
    repeat (19) tick();
    check("t5_pre_busy", 32'(busy), 32'd1);
    check("t5_pre_cnt", cycle_count, 32'd19);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    branch_taken = 1'b0;
    check("t5_timeout", 32'(timeout), 32'd1);
    check("t5_done", 32'(done), 32'd1);
    check("t5_cnt", cycle_count, 32'd20);
    check("t5_pc", 32'(pc), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_to_clear", 32'(timeout), 32'd0);

    // branch at the last pc redirects instead of ending the run
    repeat (7) tick();
    check("end_pc7", 32'(pc), 32'd7);
    branch_taken = 1'b1;
    abs_jump = 1'b1;
    target = 10'd2;
    tick();
    branch_taken = 1'b0;
    check("end_redirect_pc", 32'(pc), 32'd2);
    check("end_redirect_busy", 32'(busy), 32'd1);

    // 6: start ignored while busy, asynchronous reset mid-run
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_start_ign_pc", 32'(pc), 32'd3);
    check("t6_start_ign_cnt", cycle_count, 32'd9);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_pc", 32'(pc), 32'd0);
    check("t6_async_cnt", cycle_count, 32'd0);
    check("t6_async_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    check("t6_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
